// File: rtl/ctrl_bm_gen.sv
// Bin-manager run controller: sequences bin info read, per-bin load/solve/update
// and conflict backtracking across bins, with a per-phase watchdog and abort.
module ctrl_bm_gen #(
  parameter int unsigned WIDTH_BIN_ID  = 10,
  parameter int unsigned WIDTH_CLAUSES = 16,
  parameter int unsigned WIDTH_LVL     = 16,
  parameter int unsigned WIDTH_TO      = 16,
  parameter int unsigned WIDTH_STAT    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_bm_i,
  input  logic                     abort_i,
  output logic                     done_bm_o,
  output logic [1:0]               result_o,
  output logic [2:0]               err_phase_o,
  output logic [WIDTH_BIN_ID-1:0]  cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]     cur_lvl_o,
  output logic                     start_rdinfo_o,
  output logic                     start_load_o,
  output logic                     start_core_o,
  output logic                     start_find_o,
  output logic                     start_bkt_o,
  output logic                     start_update_o,
  input  logic                     done_rdinfo_i,
  input  logic                     done_load_i,
  input  logic                     done_core_i,
  input  logic                     done_find_i,
  input  logic                     done_bkt_i,
  input  logic                     done_update_i,
  input  logic [WIDTH_CLAUSES-1:0] nb_all_i,
  output logic [WIDTH_BIN_ID-1:0]  request_bin_num_o,
  output logic [WIDTH_BIN_ID-1:0]  update_bin_num_o,
  input  logic                     local_sat_i,
  input  logic [WIDTH_LVL-1:0]     cur_lvl_from_core_i,
  input  logic [WIDTH_LVL-1:0]     bkt_lvl_from_find_i,
  input  logic [WIDTH_BIN_ID-1:0]  bkt_bin_from_find_i,
  output logic [WIDTH_STAT-1:0]    cnt_load_o,
  output logic [WIDTH_STAT-1:0]    cnt_conflict_o
);

  localparam int unsigned CMP_W = (WIDTH_BIN_ID > WIDTH_CLAUSES) ? WIDTH_BIN_ID : WIDTH_CLAUSES;
  localparam logic [WIDTH_TO-1:0]   WD_LAST  = {{(WIDTH_TO-1){1'b1}}, 1'b0};
  localparam logic [WIDTH_STAT-1:0] STAT_MAX = '1;
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_SAT   = 2'd1;
  localparam logic [1:0] RES_UNSAT = 2'd2;
  localparam logic [1:0] RES_ABORT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_RD_BIN_INFO    = 3'd1,
    S_LOAD_BIN       = 3'd2,
    S_RUN_CORE       = 3'd3,
    S_FIND_BKT_LVL   = 3'd4,
    S_BKT_ACROSS_BIN = 3'd5,
    S_UPDATE_BIN     = 3'd6,
    S_DONE           = 3'd7
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDTH_TO-1:0]      wd_q, wd_d;
  logic [WIDTH_CLAUSES-1:0] nb_all_q, nb_all_d;
  logic                     last_sat_q, last_sat_d;
  logic                     done_bm_q, done_bm_d;
  logic [1:0]               result_q, result_d;
  logic [2:0]               err_phase_q, err_phase_d;
  logic [WIDTH_BIN_ID-1:0]  cur_bin_q, cur_bin_d;
  logic [WIDTH_BIN_ID-1:0]  update_bin_q, update_bin_d;
  logic [WIDTH_LVL-1:0]     cur_lvl_q, cur_lvl_d;
  logic [WIDTH_STAT-1:0]    cnt_load_q, cnt_load_d;
  logic [WIDTH_STAT-1:0]    cnt_conflict_q, cnt_conflict_d;
  logic [5:0]               start_q, start_d;
  logic                     active_c;
  logic                     phase_done_c;
  logic                     last_bin_c;
  logic                     entering_c;

  // Done of the phase currently owned by the FSM; all others are ignored.
  always_comb begin
    phase_done_c = 1'b0;
    case (state_q)
      S_RD_BIN_INFO:    phase_done_c = done_rdinfo_i;
      S_LOAD_BIN:       phase_done_c = done_load_i;
      S_RUN_CORE:       phase_done_c = done_core_i;
      S_FIND_BKT_LVL:   phase_done_c = done_find_i;
      S_BKT_ACROSS_BIN: phase_done_c = done_bkt_i;
      S_UPDATE_BIN:     phase_done_c = done_update_i;
      default:          phase_done_c = 1'b0;
    endcase
  end

  assign active_c   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign last_bin_c = (CMP_W'(cur_bin_q) == CMP_W'(nb_all_q));

  always_comb begin
    state_d        = state_q;
    nb_all_d       = nb_all_q;
    last_sat_d     = last_sat_q;
    done_bm_d      = done_bm_q;
    result_d       = result_q;
    err_phase_d    = err_phase_q;
    cur_bin_d      = cur_bin_q;
    update_bin_d   = update_bin_q;
    cur_lvl_d      = cur_lvl_q;
    cnt_load_d     = cnt_load_q;
    cnt_conflict_d = cnt_conflict_q;
    wd_d           = '0;
    start_d        = '0;
    entering_c     = 1'b0;

    if (active_c && (abort_i || (!phase_done_c && (wd_q == WD_LAST)))) begin
      state_d     = S_DONE;
      result_d    = RES_ABORT;
      err_phase_d = state_q;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_bm_i) begin
            state_d        = S_RD_BIN_INFO;
            result_d       = RES_NONE;
            done_bm_d      = 1'b0;
            err_phase_d    = '0;
            cnt_load_d     = '0;
            cnt_conflict_d = '0;
            cur_bin_d      = WIDTH_BIN_ID'(1);
            cur_lvl_d      = '0;
          end
        end
        S_RD_BIN_INFO: begin
          if (done_rdinfo_i) begin
            nb_all_d = nb_all_i;
            if (nb_all_i == '0) begin
              state_d  = S_DONE;
              result_d = RES_SAT;
            end else begin
              state_d = S_LOAD_BIN;
            end
          end
        end
        S_LOAD_BIN: begin
          if (done_load_i) begin
            state_d = S_RUN_CORE;
            if (cnt_load_q != STAT_MAX) cnt_load_d = cnt_load_q + WIDTH_STAT'(1);
          end
        end
        S_RUN_CORE: begin
          if (done_core_i) begin
            last_sat_d = local_sat_i;
            if (local_sat_i) begin
              cur_lvl_d = cur_lvl_from_core_i;
              state_d   = S_UPDATE_BIN;
            end else begin
              state_d = S_FIND_BKT_LVL;
              if (cnt_conflict_q != STAT_MAX) cnt_conflict_d = cnt_conflict_q + WIDTH_STAT'(1);
            end
          end
        end
        S_FIND_BKT_LVL: begin
          if (done_find_i) begin
            cur_bin_d = bkt_bin_from_find_i;
            cur_lvl_d = bkt_lvl_from_find_i;
            if (bkt_bin_from_find_i != '0) begin
              state_d = S_BKT_ACROSS_BIN;
            end else begin
              state_d  = S_DONE;
              result_d = RES_UNSAT;
            end
          end
        end
        S_BKT_ACROSS_BIN: begin
          if (done_bkt_i) state_d = S_UPDATE_BIN;
        end
        S_UPDATE_BIN: begin
          if (done_update_i) begin
            if (last_sat_q && last_bin_c) begin
              state_d  = S_DONE;
              result_d = RES_SAT;
            end else begin
              state_d = S_LOAD_BIN;
              if (last_sat_q) cur_bin_d = cur_bin_q + WIDTH_BIN_ID'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Entry side effects: watchdog restart, start pulses, write-back bin latch.
    entering_c = (state_d != state_q);
    if (active_c && !entering_c) wd_d = wd_q + WIDTH_TO'(1);
    if (entering_c) begin
      case (state_d)
        S_RD_BIN_INFO:    start_d[0] = 1'b1;
        S_LOAD_BIN: begin
          start_d[1]   = 1'b1;
          update_bin_d = cur_bin_d;
        end
        S_RUN_CORE:       start_d[2] = 1'b1;
        S_FIND_BKT_LVL:   start_d[3] = 1'b1;
        S_BKT_ACROSS_BIN: start_d[4] = 1'b1;
        S_UPDATE_BIN:     start_d[5] = 1'b1;
        S_DONE:           done_bm_d  = 1'b1;
        default:          start_d    = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wd_q           <= '0;
      nb_all_q       <= '0;
      last_sat_q     <= 1'b0;
      done_bm_q      <= 1'b0;
      result_q       <= RES_NONE;
      err_phase_q    <= '0;
      cur_bin_q      <= WIDTH_BIN_ID'(1);
      update_bin_q   <= '0;
      cur_lvl_q      <= '0;
      cnt_load_q     <= '0;
      cnt_conflict_q <= '0;
      start_q        <= '0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      nb_all_q       <= nb_all_d;
      last_sat_q     <= last_sat_d;
      done_bm_q      <= done_bm_d;
      result_q       <= result_d;
      err_phase_q    <= err_phase_d;
      cur_bin_q      <= cur_bin_d;
      update_bin_q   <= update_bin_d;
      cur_lvl_q      <= cur_lvl_d;
      cnt_load_q     <= cnt_load_d;
      cnt_conflict_q <= cnt_conflict_d;
      start_q        <= start_d;
    end
  end

  assign done_bm_o         = done_bm_q;
  assign result_o          = result_q;
  assign err_phase_o       = err_phase_q;
  assign cur_bin_num_o     = cur_bin_q;
  assign request_bin_num_o = cur_bin_q;
  assign update_bin_num_o  = update_bin_q;
  assign cur_lvl_o         = cur_lvl_q;
  assign cnt_load_o        = cnt_load_q;
  assign cnt_conflict_o    = cnt_conflict_q;
  assign start_rdinfo_o    = start_q[0];
  assign start_load_o      = start_q[1];
  assign start_core_o      = start_q[2];
  assign start_find_o      = start_q[3];
  assign start_bkt_o       = start_q[4];
  assign start_update_o    = start_q[5];

endmodule

// File: tb/tb_ctrl_bm_gen.sv
// Directed bench for ctrl_bm_gen: phase handshakes driven by hand, outputs
// compared against hand-computed values.
module tb_ctrl_bm_gen;

  localparam int unsigned BW = 10;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 16;
  localparam int unsigned TW = 4;
  localparam int unsigned SW = 32;

  logic          clk;
  logic          rst;
  logic          start_bm;
  logic          abort;
  logic          done_bm;
  logic [1:0]    result;
  logic [2:0]    err_phase;
  logic [BW-1:0] cur_bin;
  logic [LW-1:0] cur_lvl;
  logic          st_rdinfo, st_load, st_core, st_find, st_bkt, st_update;
  logic [5:0]    dones;
  logic [CW-1:0] nb_all;
  logic [BW-1:0] req_bin;
  logic [BW-1:0] upd_bin;
  logic          local_sat;
  logic [LW-1:0] lvl_core;
  logic [LW-1:0] bkt_lvl;
  logic [BW-1:0] bkt_bin;
  logic [SW-1:0] cnt_load;
  logic [SW-1:0] cnt_conflict;
  logic [5:0]    starts;

  int total = 0;
  int bad   = 0;

  assign starts = {st_update, st_bkt, st_find, st_core, st_load, st_rdinfo};

  ctrl_bm_gen #(
    .WIDTH_BIN_ID (BW),
    .WIDTH_CLAUSES(CW),
    .WIDTH_LVL    (LW),
    .WIDTH_TO     (TW),
    .WIDTH_STAT   (SW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_bm_i         (start_bm),
    .abort_i            (abort),
    .done_bm_o          (done_bm),
    .result_o           (result),
    .err_phase_o        (err_phase),
    .cur_bin_num_o      (cur_bin),
    .cur_lvl_o          (cur_lvl),
    .start_rdinfo_o     (st_rdinfo),
    .start_load_o       (st_load),
    .start_core_o       (st_core),
    .start_find_o       (st_find),
    .start_bkt_o        (st_bkt),
    .start_update_o     (st_update),
    .done_rdinfo_i      (dones[0]),
    .done_load_i        (dones[1]),
    .done_core_i        (dones[2]),
    .done_find_i        (dones[3]),
    .done_bkt_i         (dones[4]),
    .done_update_i      (dones[5]),
    .nb_all_i           (nb_all),
    .request_bin_num_o  (req_bin),
    .update_bin_num_o   (upd_bin),
    .local_sat_i        (local_sat),
    .cur_lvl_from_core_i(lvl_core),
    .bkt_lvl_from_find_i(bkt_lvl),
    .bkt_bin_from_find_i(bkt_bin),
    .cnt_load_o         (cnt_load),
    .cnt_conflict_o     (cnt_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the start pulse of phase idx.
  task automatic wait_start(input int idx, input string tag);
    int n = 0;
    while (!starts[idx] && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(starts[idx]), 32'd1);
  endtask

  task automatic finish(input int idx);
    dones[idx] = 1'b1;
    step();
    dones = '0;
  endtask

  task automatic kick();
    start_bm = 1'b1;
    step();
    start_bm = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; start_bm = 1'b0; abort = 1'b0; dones = '0;
    nb_all = '0; local_sat = 1'b0; lvl_core = '0; bkt_lvl = '0; bkt_bin = '0;
    step();
    step();
    chk("rst_done", 32'(done_bm), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cur_bin", 32'(cur_bin), 32'd1);
    chk("rst_req_bin", 32'(req_bin), 32'd1);
    chk("rst_starts", 32'(starts), 32'd0);
    rst = 1'b0;
    step();

    // Three bins, every core SAT.
    kick();
    wait_start(0, "t1_rdinfo");
    nb_all = CW'(3);
    finish(0);
    for (int b = 1; b <= 3; b++) begin
      wait_start(1, "t1_load");
      chk("t1_cur_bin", 32'(cur_bin), 32'(b));
      chk("t1_req_bin", 32'(req_bin), 32'(b));
      chk("t1_upd_bin", 32'(upd_bin), 32'(b));
      finish(1);
      wait_start(2, "t1_core");
      local_sat = 1'b1; lvl_core = LW'(b * 10);
      finish(2);
      wait_start(5, "t1_update");
      finish(5);
    end
    chk("t1_done", 32'(done_bm), 32'd1);
    chk("t1_result", 32'(result), 32'd1);
    chk("t1_cnt_load", cnt_load, 32'd3);
    chk("t1_cnt_conf", cnt_conflict, 32'd0);
    chk("t1_lvl", 32'(cur_lvl), 32'd30);
    step();
    chk("t1_done_hold", 32'(done_bm), 32'd1);

    // Conflict in bin 2 backtracks to bin 1, then a root-level conflict.
    kick();
    chk("t2_done_clr", 32'(done_bm), 32'd0);
    chk("t2_result_clr", 32'(result), 32'd0);
    wait_start(0, "t2_rdinfo");
    nb_all = CW'(3);
    finish(0);
    wait_start(1, "t2_load1");
    finish(1);
    wait_start(2, "t2_core1");
    local_sat = 1'b1; lvl_core = LW'(2);
    finish(2);
    wait_start(5, "t2_update1");
    finish(5);
    wait_start(1, "t2_load2");
    chk("t2_bin2", 32'(cur_bin), 32'd2);
    finish(1);
    wait_start(2, "t2_core2");
    local_sat = 1'b0;
    finish(2);
    wait_start(3, "t2_find");
    bkt_bin = BW'(1); bkt_lvl = LW'(4);
    finish(3);
    chk("t2_bkt_bin", 32'(cur_bin), 32'd1);
    chk("t2_bkt_lvl", 32'(cur_lvl), 32'd4);
    chk("t2_cnt_conf", cnt_conflict, 32'd1);
    wait_start(4, "t2_bkt");
    finish(4);
    wait_start(5, "t2_update2");
    chk("t2_upd_bin2", 32'(upd_bin), 32'd2);
    finish(5);
    wait_start(1, "t2_reload");
    chk("t2_reload_bin", 32'(cur_bin), 32'd1);
    chk("t2_reload_upd", 32'(upd_bin), 32'd1);
    chk("t2_cnt_load", cnt_load, 32'd2);
    finish(1);
    wait_start(2, "t2_core3");
    local_sat = 1'b0;
    finish(2);
    wait_start(3, "t2_find2");
    bkt_bin = '0; bkt_lvl = '0;
    finish(3);
    chk("t2_unsat", 32'(result), 32'd2);
    chk("t2_done", 32'(done_bm), 32'd1);
    chk("t2_cnt_conf2", cnt_conflict, 32'd2);
    chk("t2_cnt_load2", cnt_load, 32'd3);

    // Load never completes: watchdog aborts after 15 cycles in LOAD_BIN.
    kick();
    wait_start(0, "t3_rdinfo");
    nb_all = CW'(3);
    finish(0);
    wait_start(1, "t3_load");
    n = 0;
    while (!done_bm && n < 40) begin
      step();
      n++;
    end
    chk("t3_wd_cycles", 32'(n), 32'd15);
    chk("t3_result", 32'(result), 32'd3);
    chk("t3_err_phase", 32'(err_phase), 32'd2);

    // Abort together with core done: abort wins, no further phase starts.
    kick();
    chk("t4_err_clr", 32'(err_phase), 32'd0);
    wait_start(0, "t4_rdinfo");
    finish(0);
    wait_start(1, "t4_load");
    finish(1);
    wait_start(2, "t4_core");
    local_sat = 1'b1; lvl_core = LW'(77); abort = 1'b1;
    finish(2);
    abort = 1'b0;
    chk("t4_result", 32'(result), 32'd3);
    chk("t4_err_phase", 32'(err_phase), 32'd3);
    chk("t4_done", 32'(done_bm), 32'd1);
    chk("t4_lvl", 32'(cur_lvl), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (st_update || st_find) seen++;
      step();
    end
    chk("t4_no_pulse", 32'(seen), 32'd0);

    // Reset in RUN_CORE, then a clean single-bin rerun.
    kick();
    wait_start(0, "t5_rdinfo");
    finish(0);
    wait_start(1, "t5_load");
    finish(1);
    wait_start(2, "t5_core");
    rst = 1'b1;
    step();
    chk("t5_rst_starts", 32'(starts), 32'd0);
    chk("t5_rst_cur_bin", 32'(cur_bin), 32'd1);
    chk("t5_rst_cnt_load", cnt_load, 32'd0);
    chk("t5_rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_post_starts", 32'(starts), 32'd0);
    kick();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (st_rdinfo) seen++;
      if (i < 4) step();
    end
    chk("t5_rdinfo_pulses", 32'(seen), 32'd1);
    nb_all = CW'(1);
    dones[0] = 1'b1;
    step();
    dones = '0;
    wait_start(1, "t5_load2");
    finish(1);
    wait_start(2, "t5_core2");
    local_sat = 1'b1; lvl_core = LW'(9);
    finish(2);
    wait_start(5, "t5_update");
    finish(5);
    chk("t5_result", 32'(result), 32'd1);
    chk("t5_lvl", 32'(cur_lvl), 32'd9);
    chk("t5_cnt_load", cnt_load, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
